// File: rtl/fetch_ctrl_pkg.sv
// Shared fetch-stage definitions: FSM states, address widths and the branch
// target table. The assembler resolves branch indices through the same table.
package fetch_ctrl_pkg;

    localparam int FETCH_PC_W     = 10;
    localparam int FETCH_IDX_W    = 5;
    localparam int FETCH_LUT_SIZE = 1 << FETCH_IDX_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } fetch_state_e;

    // Absolute branch destinations, indexed by the instruction's target field.
    localparam logic [FETCH_PC_W-1:0] BRANCH_TABLE [FETCH_LUT_SIZE] = '{
        10'h000, 10'h004, 10'h3FE, 10'h040, 10'h005, 10'h006, 10'h001, 10'h007,
        10'h100, 10'h3FF, 10'h002, 10'h003, 10'h080, 10'h3F8, 10'h000, 10'h006,
        10'h200, 10'h005, 10'h001, 10'h3FC, 10'h004, 10'h007, 10'h010, 10'h002,
        10'h3FA, 10'h003, 10'h000, 10'h006, 10'h020, 10'h001, 10'h3F0, 10'h005
    };

    function automatic logic [FETCH_PC_W-1:0] branch_target(
        input logic [FETCH_IDX_W-1:0] idx
    );
        return BRANCH_TABLE[idx];
    endfunction

endpackage

// File: rtl/fetch_ctrl_branch_lut.sv
// Combinational branch-index to absolute-address ROM built from the shared table.
module branch_lut
    import fetch_ctrl_pkg::*;
(
    input  logic [FETCH_IDX_W-1:0] idx,
    output logic [FETCH_PC_W-1:0]  addr
);

    // Pure table lookup; every index maps to a defined entry.
    always_comb begin
        addr = branch_target(idx);
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Program counter and fetch sequencer: Start/Done program handshake, branch
// redirection through the target table, and a saturating RUN cycle counter.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int PC_W     = FETCH_PC_W,
    parameter int IDX_W    = FETCH_IDX_W,
    parameter int PROG_LEN = 1024,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Start,
    input  logic             Branch,
    input  logic             Halt,
    input  logic [IDX_W-1:0] TargetIdx,
    output logic [PC_W-1:0]  ProgCtr,
    output logic             Running,
    output logic             Done,
    output logic [CNT_W-1:0] CycleCount
);

    localparam logic [PC_W-1:0]  PC_ZERO  = {PC_W{1'b0}};
    localparam logic [PC_W-1:0]  PC_ONE   = {{(PC_W-1){1'b0}}, 1'b1};
    localparam logic [PC_W-1:0]  PC_LAST  = PC_W'(PROG_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    fetch_state_e            state_r;
    fetch_state_e            state_nxt_s;
    logic [PC_W-1:0]         pc_r;
    logic [PC_W-1:0]         pc_nxt_s;
    logic [CNT_W-1:0]        cnt_r;
    logic [CNT_W-1:0]        cnt_nxt_s;
    logic [CNT_W-1:0]        cnt_inc_s;
    logic [FETCH_PC_W-1:0]   lut_addr_s;

    branch_lut u_branch_lut (
        .idx  (FETCH_IDX_W'(TargetIdx)),
        .addr (lut_addr_s)
    );

    // Saturating increment: the counter pins at all-ones rather than wrapping.
    always_comb begin
        if (cnt_r == CNT_MAX) begin
            cnt_inc_s = cnt_r;
        end else begin
            cnt_inc_s = cnt_r + CNT_ONE;
        end
    end

    // State, PC and counter registers; reset drops straight to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            pc_r    <= PC_ZERO;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_nxt_s;
            pc_r    <= pc_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next-state logic; in RUN, Start beats Halt beats Branch beats end-of-program.
    always_comb begin
        state_nxt_s = state_r;
        pc_nxt_s    = pc_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (Start) begin
                    state_nxt_s = ST_RUN;
                    pc_nxt_s    = PC_ZERO;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (Start) begin
                    pc_nxt_s  = PC_ZERO;
                    cnt_nxt_s = CNT_ZERO;
                end else if (Halt) begin
                    state_nxt_s = ST_DONE;
                    cnt_nxt_s   = cnt_inc_s;
                end else if (Branch) begin
                    pc_nxt_s  = PC_W'(lut_addr_s);
                    cnt_nxt_s = cnt_inc_s;
                end else if (pc_r == PC_LAST) begin
                    state_nxt_s = ST_DONE;
                    cnt_nxt_s   = cnt_inc_s;
                end else begin
                    pc_nxt_s  = pc_r + PC_ONE;
                    cnt_nxt_s = cnt_inc_s;
                end
            end
            ST_DONE: begin
                if (Start) begin
                    state_nxt_s = ST_RUN;
                    pc_nxt_s    = PC_ZERO;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                pc_nxt_s    = PC_ZERO;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    // Outputs decode only registered state, so no input reaches them combinationally.
    always_comb begin
        ProgCtr    = pc_r;
        CycleCount = cnt_r;
        case (state_r)
            ST_RUN: begin
                Running = 1'b1;
                Done    = 1'b0;
            end
            ST_DONE: begin
                Running = 1'b0;
                Done    = 1'b1;
            end
            default: begin
                Running = 1'b0;
                Done    = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: directed scenarios plus random traffic,
// with expectations from a behavioural program-sequencing model.
module tb_fetch_ctrl;

    localparam int PC_W     = 10;
    localparam int IDX_W    = 5;
    localparam int PROG_LEN = 8;
    localparam int CNT_W    = 4;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;
    localparam int PC_MOD   = 1 << PC_W;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             Start;
    logic             Branch;
    logic             Halt;
    logic [IDX_W-1:0] TargetIdx;
    logic [PC_W-1:0]  ProgCtr;
    logic             Running;
    logic             Done;
    logic [CNT_W-1:0] CycleCount;

    fetch_ctrl #(
        .PC_W     (PC_W),
        .IDX_W    (IDX_W),
        .PROG_LEN (PROG_LEN),
        .CNT_W    (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Start      (Start),
        .Branch     (Branch),
        .Halt       (Halt),
        .TargetIdx  (TargetIdx),
        .ProgCtr    (ProgCtr),
        .Running    (Running),
        .Done       (Done),
        .CycleCount (CycleCount)
    );

    always #5 clk = ~clk;

    // Branch destinations as published to the assembler.
    int lut [32] = '{
        'h000, 'h004, 'h3FE, 'h040, 'h005, 'h006, 'h001, 'h007,
        'h100, 'h3FF, 'h002, 'h003, 'h080, 'h3F8, 'h000, 'h006,
        'h200, 'h005, 'h001, 'h3FC, 'h004, 'h007, 'h010, 'h002,
        'h3FA, 'h003, 'h000, 'h006, 'h020, 'h001, 'h3F0, 'h005
    };

    typedef struct {
        int pc;
        bit run;
        bit done;
        int cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Model: is a program active, has it finished, where is it, how long has it run.
    bit m_run;
    bit m_done;
    int m_pc;
    int m_cnt;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_done = 0; m_pc = 0; m_cnt = 0;
    endtask

    task automatic model_step(input bit rn, input bit s, input bit b, input bit h, input int idx);
        if (!rn) begin
            model_reset();
        end else if (s) begin
            m_run = 1; m_done = 0; m_pc = 0; m_cnt = 0;
        end else if (m_run) begin
            if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
            if (h) begin
                m_run = 0; m_done = 1;
            end else if (b) begin
                m_pc = lut[idx];
            end else if (m_pc == PROG_LEN - 1) begin
                m_run = 0; m_done = 1;
            end else begin
                m_pc = (m_pc + 1) % PC_MOD;
            end
        end
    endtask

    // One clock of stimulus: drive at the falling edge and queue the post-edge expectation.
    task automatic cycle(input bit rn, input bit s, input bit b, input bit h, input int idx);
        exp_t e;
        @(negedge clk);
        rst_n     = rn;
        Start     = s;
        Branch    = b;
        Halt      = h;
        TargetIdx = IDX_W'(idx);
        model_step(rn, s, b, h, idx);
        e.pc = m_pc; e.run = m_run; e.done = m_done; e.cnt = m_cnt;
        exp_q.push_back(e);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor: every rising edge with a pending expectation is compared against the DUT.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sb_pc", int'(ProgCtr), e.pc);
                check("sb_running", int'(Running), int'(e.run));
                check("sb_done", int'(Done), int'(e.done));
                check("sb_count", int'(CycleCount), e.cnt);
            end
        end
    end

    initial begin
        #300000;
        errors++;
        $display("FAIL watchdog expired actual=timeout expected=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        rst_n = 1'b0; Start = 1'b0; Branch = 1'b0; Halt = 1'b0; TargetIdx = '0;
        model_reset();
        #2;
        check("reset_pc", int'(ProgCtr), 0);
        check("reset_running", int'(Running), 0);
        check("reset_done", int'(Done), 0);
        check("reset_count", int'(CycleCount), 0);
        repeat (2) cycle(0, 0, 0, 0, 0);
        repeat (2) cycle(1, 0, 1, 1, 3);
        settle();
        check("idle_ignores_branch", int'(ProgCtr), 0);
        check("idle_stays", int'(Running), 0);

        // Straight-line program to its last instruction, then holding in DONE.
        cycle(1, 1, 0, 0, 0);
        repeat (12) cycle(1, 0, 0, 0, 0);
        settle();
        check("seq_done", int'(Done), 1);
        check("seq_last_pc", int'(ProgCtr), 7);
        check("seq_count", int'(CycleCount), 8);

        // Branch at PC 5 to table entry 3, then sequential from the target.
        cycle(1, 1, 0, 0, 0);
        repeat (5) cycle(1, 0, 0, 0, 0);
        settle();
        check("pre_branch_pc", int'(ProgCtr), 5);
        cycle(1, 0, 1, 0, 3);
        settle();
        check("branch_target", int'(ProgCtr), 'h040);
        cycle(1, 0, 0, 0, 0);
        settle();
        check("branch_plus_one", int'(ProgCtr), 'h041);

        // Halt beats Branch.
        cycle(1, 0, 1, 1, 3);
        settle();
        check("halt_wins_done", int'(Done), 1);
        check("halt_wins_pc", int'(ProgCtr), 'h041);
        cycle(1, 0, 1, 0, 7);

        // Restart out of DONE.
        cycle(1, 1, 0, 0, 0);
        settle();
        check("restart_done", int'(Done), 0);
        check("restart_running", int'(Running), 1);
        check("restart_pc", int'(ProgCtr), 0);
        check("restart_count", int'(CycleCount), 0);

        // Start beats Halt.
        repeat (3) cycle(1, 0, 0, 0, 0);
        cycle(1, 1, 0, 1, 0);
        settle();
        check("start_wins_pc", int'(ProgCtr), 0);
        check("start_wins_running", int'(Running), 1);

        // Branch on the last instruction is taken instead of ending.
        repeat (7) cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 1, 0, 1);
        settle();
        check("last_branch_pc", int'(ProgCtr), 4);
        check("last_branch_running", int'(Running), 1);

        // Looping branch keeps the program alive until the counter saturates.
        cycle(1, 1, 0, 0, 0);
        repeat (20) cycle(1, 0, 1, 0, 3);
        settle();
        check("sat_count", int'(CycleCount), CNT_MAX);

        // Reset between edges takes effect without waiting for the clock.
        cycle(1, 1, 0, 0, 0);
        repeat (5) cycle(1, 0, 0, 0, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_pc", int'(ProgCtr), 0);
        check("async_rst_running", int'(Running), 0);
        check("async_rst_count", int'(CycleCount), 0);
        model_reset();
        cycle(0, 0, 0, 0, 0);
        repeat (3) cycle(1, 0, 0, 0, 0);
        settle();
        check("post_rst_needs_start", int'(Running), 0);

        // Random traffic, including occasional resets.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 49) != 0),
                  ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 19) == 0),
                  int'($urandom_range(0, 31)));
        end

        repeat (2) @(posedge clk);
        #3;
        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
